// File: rtl/oai_mn_reg_bist_if.sv
// Bus bundle for oai_mn_reg_bist: functional inputs, BIST controls and status.
interface oai_mn_reg_bist_if #(
  parameter int NA  = 3,
  parameter int NB  = 2,
  parameter int NCH = 4
);
  logic                  EN;
  logic [NCH*NA-1:0]     A;
  logic [NCH*NB-1:0]     B;
  logic                  START;
  logic [NCH-1:0]        FI;
  logic [NCH-1:0]        ZN;
  logic                  BUSY;
  logic                  DONE;
  logic                  PASS;
  logic [NCH-1:0]        FAIL;
  logic [NA+NB:0]        ZCNT;

  modport master (
    output EN, A, B, START, FI,
    input  ZN, BUSY, DONE, PASS, FAIL, ZCNT
  );

  modport slave (
    input  EN, A, B, START, FI,
    output ZN, BUSY, DONE, PASS, FAIL, ZCNT
  );
endinterface

// File: rtl/oai_mn_reg_bist.sv
// Multi-channel registered OR-AND-INVERT with a built-in exhaustive self-test.
// Each channel: ZN = ~((|A_c) & (|B_c)). The BIST sweeps all 2^(NA+NB)
// vectors through every channel and compares the captured output against a
// golden value registered alongside it.
module oai_mn_reg_bist #(
  parameter int NA  = 3,
  parameter int NB  = 2,
  parameter int NCH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  oai_mn_reg_bist_if.slave bus
);

  localparam int unsigned VW     = NA + NB + 1;
  localparam int unsigned N      = 1 << (NA + NB);
  localparam logic [VW-1:0] V_LAST = VW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [VW-1:0]     v;
  logic [NCH-1:0]    zn_q;
  logic [NCH-1:0]    fail_q;
  logic              pass_q;
  logic              e_q;
  logic [VW-1:0]     zcnt_q;

  logic [NA-1:0]     a_mux [NCH];
  logic [NB-1:0]     b_mux [NCH];
  logic [NCH-1:0]    oai_c;
  logic              golden;
  logic [NCH-1:0]    cmp;

  // Channel input mux (BIST vector during SWEEP) and per-channel OAI evaluation.
  always_comb begin
    oai_c  = '1;
    golden = ~((|v[NA-1:0]) & (|v[NA+NB-1:NA]));
    cmp    = zn_q ^ {NCH{e_q}};
    for (int unsigned c = 0; c < NCH; c++) begin
      if (state == S_SWEEP) begin
        a_mux[c] = v[NA-1:0];
        b_mux[c] = v[NA+NB-1:NA];
      end else begin
        a_mux[c] = bus.A[c*NA +: NA];
        b_mux[c] = bus.B[c*NB +: NB];
      end
      oai_c[c] = ~((|a_mux[c]) & (|b_mux[c]));
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: START only honoured in IDLE; sweep ends on the last vector.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.START) state_nx = S_SWEEP;
      S_SWEEP: if (v == V_LAST) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: functional capture, BIST capture/compare, result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      zn_q   <= '1;
      v      <= '0;
      fail_q <= '0;
      pass_q <= 1'b0;
      e_q    <= 1'b0;
      zcnt_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.EN) zn_q <= oai_c;
          if (bus.START) begin
            v      <= '0;
            fail_q <= '0;
            pass_q <= 1'b0;
            zcnt_q <= '0;
          end
        end
        S_SWEEP: begin
          zn_q <= oai_c ^ bus.FI;
          e_q  <= golden;
          // First SWEEP cycle has nothing captured yet to compare.
          if (v != '0) fail_q <= fail_q | cmp;
          if (!golden) zcnt_q <= zcnt_q + VW'(1);
          v <= v + VW'(1);
        end
        S_FLUSH: begin
          // Verdict is registered here so PASS is already valid while DONE is high.
          fail_q <= fail_q | cmp;
          pass_q <= ~|(fail_q | cmp);
        end
        default: ;
      endcase
    end
  end

  // Status decode and output drive.
  always_comb begin
    bus.ZN   = zn_q;
    bus.BUSY = (state == S_SWEEP) || (state == S_FLUSH);
    bus.DONE = (state == S_DONE);
    bus.PASS = pass_q;
    bus.FAIL = fail_q;
    bus.ZCNT = zcnt_q;
  end

endmodule

// File: tb/tb_oai_mn_reg_bist.sv
// Self-checking bench for oai_mn_reg_bist: default instance plus two
// parameter corners, checked against a behavioural reference model.
module tb_oai_mn_reg_bist;

  localparam int ND = 32;
  localparam int NS = 4;
  localparam int NL = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oai_mn_reg_bist_if #(.NA(3), .NB(2), .NCH(4))  ifd ();
  oai_mn_reg_bist_if #(.NA(1), .NB(1), .NCH(1))  ifs ();
  oai_mn_reg_bist_if #(.NA(4), .NB(4), .NCH(16)) ifl ();

  oai_mn_reg_bist #(.NA(3), .NB(2), .NCH(4))  dut_d (.CLK(clk), .RST(rst), .bus(ifd));
  oai_mn_reg_bist #(.NA(1), .NB(1), .NCH(1))  dut_s (.CLK(clk), .RST(rst), .bus(ifs));
  oai_mn_reg_bist #(.NA(4), .NB(4), .NCH(16)) dut_l (.CLK(clk), .RST(rst), .bus(ifl));

  int unsigned npass = 0;
  int unsigned nfail = 0;
  int unsigned ntot  = 0;
  logic [3:0]  zn_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: channel output is 0 only when both groups have some bit set.
  function automatic logic [3:0] oai_ref(input logic [11:0] a, input logic [7:0] b);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) begin
      int unsigned ra, rb;
      ra = (32'(a) >> (3 * c)) % 8;
      rb = (32'(b) >> (2 * c)) % 4;
      r[c] = !(ra != 0 && rb != 0);
    end
    return r;
  endfunction

  task automatic run_bist(input logic [3:0] fi, input int glitch_at, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    ifd.FI    = fi;
    ifd.EN    = 1'b0;
    ifd.START = 1'b1;
    tick();
    ifd.START = 1'b0;
    for (int j = 0; j <= ND + 8; j++) begin
      if (ifd.BUSY) busy_cnt++;
      if (ifd.DONE) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      if (j <= ND + 1) begin
        ifd.EN = 1'($urandom);
        ifd.A  = 12'($urandom);
        ifd.B  = 8'($urandom);
      end else begin
        ifd.EN = 1'b0;
      end
      ifd.START = (j == glitch_at);
      tick();
    end
    ifd.START = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(ND + 1));
    chk({tag, "_done_at"},     64'(done_at),  64'(ND + 1));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_pass"},        64'(ifd.PASS), 64'(fi == 4'd0));
    chk({tag, "_fail"},        64'(ifd.FAIL), 64'(fi));
    chk({tag, "_zcnt"},        64'(ifd.ZCNT), 64'((8 - 1) * (4 - 1)));
    // Last swept vector is all-ones, whose golden output is 0.
    chk({tag, "_zn_after"},    64'(ifd.ZN),   64'(fi));
    zn_m = fi;
  endtask

  task automatic run_corner(input int which, input logic [15:0] fi, input string tag);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    int n;
    int zexp;
    logic b, d;
    n    = (which == 0) ? NS : NL;
    zexp = (which == 0) ? 1 : 15 * 15;
    if (which == 0) begin
      ifs.FI = fi[0:0];
      ifs.START = 1'b1;
    end else begin
      ifl.FI = fi;
      ifl.START = 1'b1;
    end
    tick();
    ifs.START = 1'b0;
    ifl.START = 1'b0;
    for (int j = 0; j <= n + 8; j++) begin
      b = (which == 0) ? ifs.BUSY : ifl.BUSY;
      d = (which == 0) ? ifs.DONE : ifl.DONE;
      if (b) busy_cnt++;
      if (d) begin
        done_cnt++;
        if (done_at < 0) done_at = j;
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n + 1));
    chk({tag, "_done_at"},     64'(done_at),  64'(n + 1));
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    if (which == 0) begin
      chk({tag, "_zcnt"}, 64'(ifs.ZCNT), 64'(zexp));
      chk({tag, "_pass"}, 64'(ifs.PASS), 64'(fi[0] == 1'b0));
      chk({tag, "_fail"}, 64'(ifs.FAIL), 64'(fi[0]));
    end else begin
      chk({tag, "_zcnt"}, 64'(ifl.ZCNT), 64'(zexp));
      chk({tag, "_pass"}, 64'(ifl.PASS), 64'(fi == 16'd0));
      chk({tag, "_fail"}, 64'(ifl.FAIL), 64'(fi));
    end
  endtask

  initial begin
    int dcnt;
    logic [3:0] rfi;
    logic [15:0] lfi;
    ifd.EN = 1'b0; ifd.A = '0; ifd.B = '0; ifd.START = 1'b0; ifd.FI = '0;
    ifs.EN = 1'b0; ifs.A = '0; ifs.B = '0; ifs.START = 1'b0; ifs.FI = '0;
    ifl.EN = 1'b0; ifl.A = '0; ifl.B = '0; ifl.START = 1'b0; ifl.FI = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_zn",   64'(ifd.ZN),   64'hF);
    chk("rst_busy", 64'(ifd.BUSY), 64'd0);
    chk("rst_done", 64'(ifd.DONE), 64'd0);
    chk("rst_pass", 64'(ifd.PASS), 64'd0);
    chk("rst_fail", 64'(ifd.FAIL), 64'd0);
    chk("rst_zcnt", 64'(ifd.ZCNT), 64'd0);
    chk("rst_zn_s", 64'(ifs.ZN),   64'h1);
    chk("rst_zn_l", 64'(ifl.ZN),   64'hFFFF);
    zn_m = 4'hF;

    // Directed functional steps on channel 0.
    ifd.A = 12'b000_000_000_100; ifd.B = 8'b00_00_00_01; ifd.EN = 1'b1;
    tick();
    chk("func_ch0_low", 64'(ifd.ZN), 64'(4'b1110));
    ifd.B = '0;
    tick();
    chk("func_b_zero", 64'(ifd.ZN), 64'hF);
    ifd.EN = 1'b0; ifd.A = 12'hFFF; ifd.B = 8'hFF;
    tick();
    chk("func_en_hold", 64'(ifd.ZN), 64'hF);

    // Random functional traffic; FI must have no effect here.
    for (int i = 0; i < 40; i++) begin
      ifd.A  = 12'($urandom);
      ifd.B  = 8'($urandom);
      ifd.EN = 1'($urandom);
      ifd.FI = 4'($urandom);
      if (ifd.EN) zn_m = oai_ref(ifd.A, ifd.B);
      tick();
      chk("func_rand", 64'(ifd.ZN), 64'(zn_m));
    end
    ifd.EN = 1'b0;

    run_bist(4'b0000, -1, "bist_clean");
    run_bist(4'b0100, -1, "bist_fi");
    run_bist(4'b0000, -1, "bist_reclean");
    rfi = 4'($urandom_range(1, 15));
    run_bist(rfi, 10, "bist_glitch");

    // ZN keeps the BIST value until a functional capture replaces it.
    ifd.A = 12'($urandom); ifd.B = 8'($urandom);
    tick();
    chk("post_bist_hold", 64'(ifd.ZN), 64'(zn_m));
    ifd.EN = 1'b1;
    zn_m = oai_ref(ifd.A, ifd.B);
    tick();
    ifd.EN = 1'b0;
    chk("post_bist_capture", 64'(ifd.ZN), 64'(zn_m));

    // Reset in the middle of a sweep.
    ifd.FI = 4'b1010;
    ifd.START = 1'b1;
    tick();
    ifd.START = 1'b0;
    for (int j = 0; j < 15; j++) begin
      ifd.EN = 1'($urandom);
      ifd.A  = 12'($urandom);
      ifd.B  = 8'($urandom);
      tick();
    end
    chk("mid_busy_before", 64'(ifd.BUSY), 64'd1);
    ifd.EN = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 64'(ifd.BUSY), 64'd0);
    chk("mid_rst_zn",   64'(ifd.ZN),   64'hF);
    chk("mid_rst_zcnt", 64'(ifd.ZCNT), 64'd0);
    chk("mid_rst_fail", 64'(ifd.FAIL), 64'd0);
    chk("mid_rst_pass", 64'(ifd.PASS), 64'd0);
    dcnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (ifd.DONE) dcnt++;
      tick();
    end
    chk("mid_rst_no_done", 64'(dcnt), 64'd0);
    run_bist(4'b0000, -1, "bist_after_rst");

    run_corner(0, 16'h0000, "corner_small");
    run_corner(1, 16'h0000, "corner_large");
    lfi = 16'($urandom_range(1, 65535));
    run_corner(1, lfi, "corner_large_fi");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
